// File: rtl/keypoint_pkg.sv
// Shared types for the keypoint collector.
// Coordinate/DoG widths and the queued keypoint record.
package keypoint_pkg;

  localparam int COORD_W = 10;
  localparam int DOG_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } kpState_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DOG_W-1:0]   dog;
  } kpRec_t;

endpackage

// File: rtl/keypoint_collector_fifo.sv
// First-word-fall-through keypoint queue.
// Head is forced to zero while empty so outputs read 0 in reset.
module kp_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? '0 : mem[rdPtr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/keypoint_collector.sv
// Tracks pixel position within a frame and queues keypoints.
// Drops on a full queue are flagged and counted per frame.
module keypoint_collector #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DEPTH = 16,
  parameter int DOG_W = keypoint_pkg::DOG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic             keypoint,
  input  logic [DOG_W-1:0] dog_center,
  output logic             kp_valid,
  input  logic             kp_ready,
  output logic [9:0]       kp_x,
  output logic [9:0]       kp_y,
  output logic [DOG_W-1:0] kp_dog,
  output logic             frame_done,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  import keypoint_pkg::*;

  localparam int RW = 2*COORD_W + DOG_W;

  kpState_t           state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] curX;
  logic [COORD_W-1:0] curY;
  logic               pixAct;
  logic               lastCol;
  logic               lastPix;
  logic               pushReq;
  logic               popReq;
  logic               dropNow;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [RW-1:0]      pushDat;
  logic [RW-1:0]      headDat;

  // A sof pixel is always (0,0), whatever the old counters hold.
  assign curX    = sof ? '0 : x;
  assign curY    = sof ? '0 : y;
  assign pixAct  = pix_valid && (sof || state == ACTIVE);
  assign lastCol = (curX == COORD_W'(IMG_W-1));
  assign lastPix = lastCol && (curY == COORD_W'(IMG_H-1));
  assign pushReq = pixAct && keypoint;
  assign popReq  = kp_ready && !fifoEmpty;
  assign dropNow = pushReq && fifoFull && !popReq;
  assign pushDat = {curX, curY, dog_center};

  assign kp_valid = !fifoEmpty;
  assign kp_x     = headDat[RW-1 -: COORD_W];
  assign kp_y     = headDat[DOG_W +: COORD_W];
  assign kp_dog   = headDat[DOG_W-1:0];

  // Frame FSM with raster counters and registered frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pixAct) begin
        if (lastPix) begin
          state      <= DONE;
          frame_done <= 1'b1;
          x          <= '0;
          y          <= '0;
        end else begin
          state <= ACTIVE;
          if (lastCol) begin
            x <= '0;
            y <= curY + 1'b1;
          end else begin
            x <= curX + 1'b1;
            y <= curY;
          end
        end
      end else if (sof) begin
        state <= ACTIVE;
        x     <= '0;
        y     <= '0;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

  // Per-frame drop flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (sof) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
      if (dropNow) begin
        overflow <= 1'b1;
        if (sof)
          drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hff)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  kp_fifo #(
    .DEPTH(DEPTH),
    .W(RW)
  ) uFifo (
    .clk(clk),
    .rst(rst),
    .push(pushReq),
    .pop(popReq),
    .din(pushDat),
    .dout(headDat),
    .full(fifoFull),
    .empty(fifoEmpty)
  );

endmodule

// File: tb/tb_keypoint_collector.sv
// Randomized and directed checks of keypoint_collector
// against a queue-based frame model.
module tb_keypoint_collector;

  localparam int W = 8;
  localparam int H = 4;
  localparam int D = 16;
  localparam int DW = 17;

  typedef struct {
    int x;
    int y;
    int d;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic          keypoint = 1'b0;
  logic [DW-1:0] dog_center = '0;
  logic          kp_valid;
  logic          kp_ready = 1'b0;
  logic [9:0]    kp_x;
  logic [9:0]    kp_y;
  logic [DW-1:0] kp_dog;
  logic          frame_done;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int nChecks = 0;
  int nFails = 0;

  rec_t q[$];
  bit   mInFrame = 0;
  int   mIdx = 0;
  bit   mOvf = 0;
  int   mDrops = 0;
  bit   mFd = 0;

  keypoint_collector #(
    .IMG_W(W),
    .IMG_H(H),
    .DEPTH(D),
    .DOG_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sof(sof),
    .pix_valid(pix_valid),
    .keypoint(keypoint),
    .dog_center(dog_center),
    .kp_valid(kp_valid),
    .kp_ready(kp_ready),
    .kp_x(kp_x),
    .kp_y(kp_y),
    .kp_dog(kp_dog),
    .frame_done(frame_done),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mInFrame = 0;
    mIdx = 0;
    mOvf = 0;
    mDrops = 0;
    mFd = 0;
  endtask

  task automatic modelEdge(input bit s, input bit pv, input bit k,
                           input int d, input bit r);
    bit act;
    bit pop;
    rec_t rec;
    mFd = 0;
    act = pv && (s || mInFrame);
    pop = r && (q.size() > 0);
    if (s) begin
      mIdx = 0;
      mInFrame = 1;
      mOvf = 0;
      mDrops = 0;
    end
    if (pop) void'(q.pop_front());
    if (act && k) begin
      if (q.size() < D) begin
        rec.x = mIdx % W;
        rec.y = mIdx / W;
        rec.d = d;
        q.push_back(rec);
      end else begin
        mOvf = 1;
        if (mDrops < 255) mDrops++;
      end
    end
    if (act) begin
      mIdx++;
      if (mIdx == W*H) begin
        mInFrame = 0;
        mIdx = 0;
        mFd = 1;
      end
    end
  endtask

  task automatic compareAll();
    chk("kp_valid", int'(kp_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      chk("kp_x", int'(kp_x), q[0].x);
      chk("kp_y", int'(kp_y), q[0].y);
      chk("kp_dog", int'(kp_dog), q[0].d);
    end
    chk("overflow", int'(overflow), int'(mOvf));
    chk("drop_cnt", int'(drop_cnt), mDrops);
    chk("frame_done", int'(frame_done), int'(mFd));
  endtask

  task automatic step(input bit s, input bit pv, input bit k,
                      input int d, input bit r);
    @(negedge clk);
    sof = s;
    pix_valid = pv;
    keypoint = k;
    dog_center = DW'(d);
    kp_ready = r;
    modelEdge(s, pv, k, d, r);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++)
      step(0, 0, 0, 0, 1);
    chk("drained", int'(kp_valid), 0);
  endtask

  function automatic int rdog();
    return int'($urandom & 32'h1ffff);
  endfunction

  initial begin
    int n;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_kp_valid", int'(kp_valid), 0);
    chk("rst_kp_x", int'(kp_x), 0);
    chk("rst_kp_dog", int'(kp_dog), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // keypoint on 5th pixel of row 0
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 17'h1abcd, 0);
    chk("x5_valid", int'(kp_valid), 1);
    chk("x5_x", int'(kp_x), 4);
    chk("x5_y", int'(kp_y), 0);
    chk("x5_dog", int'(kp_dog), 17'h1abcd);
    drain();

    // whole frame, then an ignored extra pixel
    step(1, 1, 1, rdog(), 1);
    for (int i = 1; i < 31; i++) step(0, 1, $urandom_range(0, 1), rdog(), 1);
    step(0, 1, 1, 777, 0);
    chk("fd_pulse", int'(frame_done), 1);
    step(0, 1, 1, 999, 0);
    chk("fd_single", int'(frame_done), 0);
    drain();

    // overflow with a stalled consumer
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, rdog(), 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_cnt", int'(drop_cnt), 4);
    step(1, 0, 0, 0, 0);
    chk("sof_ovf_clr", int'(overflow), 0);
    chk("sof_cnt_clr", int'(drop_cnt), 0);
    chk("sof_keeps", int'(kp_valid), 1);

    // push and pop on a full queue
    step(0, 1, 1, 4242, 1);
    chk("full_pp_ovf", int'(overflow), 0);
    n = 0;
    for (int i = 0; i < 40 && kp_valid; i++) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    chk("full_pp_count", n, 16);

    // reset mid-frame
    step(1, 1, 1, rdog(), 0);
    step(0, 1, 1, rdog(), 0);
    step(0, 1, 1, rdog(), 0);
    @(negedge clk);
    pix_valid = 1'b0;
    keypoint = 1'b0;
    sof = 1'b0;
    rst = 1'b0;
    modelReset();
    #1;
    chk("rst_mid_valid", int'(kp_valid), 0);
    chk("rst_mid_x", int'(kp_x), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 1, rdog(), 0);
    chk("rst_no_push", int'(kp_valid), 0);

    // restart mid-frame at (3,2)
    step(1, 1, 0, 0, 0);
    for (int i = 1; i < 19; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 31, 0);
    chk("restart_x", int'(kp_x), 0);
    chk("restart_y", int'(kp_y), 0);
    for (int i = 1; i < 31; i++) step(0, 1, 0, 0, 1);
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3, rdog(), $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/keypoint_collector.md
KEYPOINT_COLLECTOR -- requirements
Module: keypoint_collector

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per row.
REQ-002 SHALL have parameter IMG_H, default 480, meaning rows per frame.
REQ-003 SHALL have parameter DEPTH, default 16, meaning keypoint FIFO entries (power of two).
REQ-004 SHALL have parameter DOG_W, default 17, meaning DoG sample width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sof  input  1  start-of-frame strobe.
REQ-008 SHALL have port pix_valid  input  1  new DoG window/keypoint decision present this cycle.
REQ-009 SHALL have port keypoint  input  1  keypoint flag from the extrema detector, meaningful only with pix_valid.
REQ-010 SHALL have port dog_center  input  DOG_W  centre DoG sample (DoG_2_2) of the current window.
REQ-011 SHALL have port kp_valid  output  1  FIFO head holds a keypoint.
REQ-012 SHALL have port kp_ready  input  1  consumer accepts head.
REQ-013 SHALL have ports kp_x  output  10, kp_y  output  10, kp_dog  output  DOG_W: head coordinates and DoG value.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of a frame.
REQ-015 SHALL have ports overflow  output  1 (sticky drop flag) and drop_cnt  output  8 (dropped keypoints, saturating).

Function
REQ-016 SHALL implement FSM IDLE, ACTIVE, DONE; reset enters IDLE.
REQ-017 SHALL move IDLE->ACTIVE on sof; pix_valid in IDLE or DONE SHALL be ignored.
REQ-018 SHALL clear x,y counters to 0 on sof; a pixel with pix_valid in the same cycle as sof SHALL be coordinate (0,0).
REQ-019 SHALL, in ACTIVE, on pix_valid, increment x; x==IMG_W-1 wraps to 0 and increments y.
REQ-020 SHALL, on pix_valid at (IMG_W-1, IMG_H-1), go to DONE; DONE SHALL assert frame_done for exactly one cycle and return to IDLE.
REQ-021 SHALL, on sof while ACTIVE, restart counters at (0,0) and remain ACTIVE; no frame_done for the aborted frame.
REQ-022 SHALL push {x, y, dog_center} when ACTIVE, pix_valid and keypoint are all high and the FIFO is not full.
REQ-023 SHALL accept a push while full only if a pop occurs in the same cycle.
REQ-024 SHALL otherwise drop the keypoint, set overflow, and increment drop_cnt, saturating at 255.
REQ-025 SHALL clear overflow and drop_cnt on sof; the FIFO contents SHALL NOT be flushed by sof.
REQ-026 SHALL be first-word-fall-through: kp_valid = not empty; a pushed entry is visible on kp_* the cycle after the push.
REQ-027 SHALL pop on kp_valid and kp_ready; kp_ready while empty SHALL have no effect.
REQ-028 SHALL hold kp_x/kp_y/kp_dog stable while kp_valid is high and kp_ready is low.
REQ-029 SHALL allow a simultaneous push and pop when non-empty, leaving occupancy unchanged.

Reset
REQ-030 SHALL, on rst low, asynchronously clear FSM to IDLE, x=y=0, FIFO empty, kp_valid=0, frame_done=0, overflow=0, drop_cnt=0.
REQ-031 SHALL define kp_x, kp_y and kp_dog as 0 during reset.
REQ-032 SHALL, on reset mid-frame, discard all queued keypoints and ignore pixels until the next sof.

Structure
REQ-033 SHALL place DOG_W, coordinate width (10) and the packed keypoint record type in shared package keypoint_pkg.
REQ-034 SHALL implement storage as one sub-module kp_fifo: a synchronous FWFT FIFO of DEPTH entries with full/empty flags.

Verification
REQ-035 SHALL verify: sof, then keypoint at the 5th pix_valid of row 0 -> kp_valid next cycle, kp_x=4, kp_y=0, kp_dog equals driven value.
REQ-036 SHALL verify: IMG_W=8, IMG_H=4, 32 pix_valid -> frame_done a single pulse after the 32nd, FSM in IDLE; a 33rd pix_valid is ignored.
REQ-037 SHALL verify: kp_ready=0, 20 keypoints -> 16 queued, overflow=1, drop_cnt=4; next sof clears both, FIFO retains 16.
REQ-038 SHALL verify: full FIFO, push and pop in the same cycle -> push accepted, count stays 16, overflow stays 0.
REQ-039 SHALL verify: 3 keypoints queued, rst low mid-frame -> kp_valid=0 immediately; pix_valid before the next sof produces no push.
REQ-040 SHALL verify: sof at (3,2) mid-frame -> next pixel reported (0,0); no frame_done for the aborted frame.
